// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the pipelined multiplier: op encodings, pipeline depth
// and the per-op operand signedness rules.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mult_op_e;

  localparam int LATENCY = 3;

  function automatic logic src1_signed(input mult_op_e op);
    return (op == OP_MULXSS) || (op == OP_MULXSU);
  endfunction

  function automatic logic src2_signed(input mult_op_e op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/cpu_mult_slice.sv
// Registered (SLICE_W+1)x(SLICE_W+1) signed multiplier; one instance per slice pair.
module cpu_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [SLICE_W:0]     a,
  input  logic [SLICE_W:0]     b,
  output logic [2*SLICE_W+1:0] p
);

  localparam int P_W = 2*SLICE_W + 2;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  assign a_ext = P_W'($signed(a));
  assign b_ext = P_W'($signed(b));

  // Data only, qualified by the pipeline valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (en) p <= a_ext * b_ext;
  end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Three-stage pipelined integer multiplier: S1 operand register, S2 slice
// partial products, S3 summed and half-selected result.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int N    = DATA_W / SLICE_W;
  localparam int PP_W = 2*SLICE_W + 2;
  localparam int P_W  = 2*DATA_W;

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // The whole pipeline advances in lockstep unless the output is held by the
  // consumer, so in_ready is simply "the output slot will move this edge".
  logic               advance;
  logic               accept;
  logic [LATENCY-1:0] stage_valid;

  mult_op_e           s1_op;
  logic [DATA_W-1:0]  s1_a;
  logic [DATA_W-1:0]  s1_b;
  logic [TAG_W-1:0]   s1_tag;
  mult_op_e           s2_op;
  logic [TAG_W-1:0]   s2_tag;

  logic [PP_W-1:0]    pp [N][N];
  logic [P_W-1:0]     product;
  logic [DATA_W-1:0]  result_sel;

  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;
  assign accept    = in_valid && advance && !flush;
  assign out_valid = stage_valid[LATENCY-1];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid <= {stage_valid[LATENCY-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= mult_op_e'(in_op);
      s1_a   <= in_src1;
      s1_b   <= in_src2;
      s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_op  <= s1_op;
      s2_tag <= s1_tag;
    end
  end

  // Only the top slice of a signed operand carries the sign; all lower
  // slices are plain unsigned digits with a zero guard bit.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [SLICE_W:0] a_sl;
      logic [SLICE_W:0] b_sl;

      assign a_sl = {(i == N-1) && src1_signed(s1_op) && s1_a[DATA_W-1],
                     s1_a[i*SLICE_W +: SLICE_W]};
      assign b_sl = {(j == N-1) && src2_signed(s1_op) && s1_b[DATA_W-1],
                     s1_b[j*SLICE_W +: SLICE_W]};

      cpu_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
        .clk (clk),
        .en  (advance),
        .a   (a_sl),
        .b   (b_sl),
        .p   (pp[i][j])
      );
    end
  end

  // Modular sum of sign-extended, weighted partial products gives the exact
  // 2*DATA_W two's-complement product.
  always_comb begin
    product = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        product = product + (P_W'($signed(pp[i][j])) << (SLICE_W*(i+j)));
      end
    end
  end

  assign result_sel = (s2_op == OP_MUL) ? product[DATA_W-1:0]
                                        : product[P_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance && stage_valid[LATENCY-2]) begin
      out_result <= result_sel;
      out_tag    <= s2_tag;
    end
  end

endmodule
